sr_ff: RTL and testbench
========================

// Module: sr_ff
//
// PURPOSE
// - Clocked SR flip-flop with complementary outputs; basic storage primitive of the gate-level library.
// - Samples set (s) and reset (r) on the rising clock edge and holds state otherwise.
// - Drives q and its complement qb.
// - The s=r=1 ("forbidden") case is resolved deterministically by a parameter, so no X reaches downstream logic.
//
// PARAMETERS
// - INVALID_MODE  default 1  action when s=r=1 at a clock edge:
//   0=hold, 1=reset-dominant (q=0), 2=set-dominant (q=1), 3=toggle
// - RESET_VAL     default 0  value loaded into q while rst is asserted; qb always = ~RESET_VAL
//
// PORTS
// - clk  in   1  clock; all state changes on the rising edge, except reset
// - rst  in   1  asynchronous, active-low reset; 0 = reset asserted
// - s    in   1  set request, sampled at posedge clk
// - r    in   1  reset (clear) request, sampled at posedge clk
// - q    out  1  stored state, registered
// - qb   out  1  complement of q; always ~q, never equal to q
//
// BEHAVIOUR
// - One clock; reset is asynchronous and active-low.
// - Reset:
//   - rst=0 forces q=RESET_VAL and qb=~RESET_VAL immediately, with no clock needed.
//   - Reset overrides s and r.
//   - Outputs are held while rst=0.
// - Release: the first edge that can update q is the first posedge clk with rst=1. Deassertion is not internally synchronised.
// - Function table at posedge clk, with rst=1:
//   - s=0 r=0 -> q holds
//   - s=1 r=0 -> q=1
//   - s=0 r=1 -> q=0
//   - s=1 r=1 -> per INVALID_MODE; with the default (1), q=0
// - Latency: one cycle. Inputs seen at edge N appear on q/qb right after edge N. No combinational path from s/r to q/qb.
// - qb is derived from the single state register, not from a second flop, so q==qb is impossible, including during reset.
// - Reset mid-operation: rst asserted at any time, even between edges, clears q at once. Any pending s/r is discarded.
// - Inputs that change between edges have no effect. Only the value at the edge matters.
// - Unknown or illegal INVALID_MODE values behave as mode 1.
//
// STRUCTURE
// - Shared package sr_pkg holds localparams:
//   - SR_HOLD=0, SR_RST_DOM=1, SR_SET_DOM=2, SR_TOGGLE=3
//   - the function encoding {s,r}: 2'b00 hold, 2'b10 set, 2'b01 clr, 2'b11 invalid
// - Flat implementation, no sub-modules:
//   - one always block with posedge clk / negedge rst for the state
//   - next-state case on {s,r}
//   - continuous assign qb = ~q
//
// TESTING
// - rst=0 for 20 ns with s=r=0 (10 ns clock) -> q=0, qb=1 throughout, including across clock edges.
// - rst=1, s=0 r=0 for one edge -> q stays 0, qb=1.
// - s=1 r=0 for one edge -> q=1, qb=0 after that edge. Then s=0 r=0 -> q holds 1.
// - s=0 r=1 for one edge -> q=0, qb=1.
// - s=1 r=1, default INVALID_MODE -> q=0, qb=1. Repeat for each mode from q=1:
//   - mode 0 -> q=1
//   - mode 2 -> q=1
//   - mode 3 -> q=0
// - Asynchronous reset:
//   - set q=1, then pull rst low mid-cycle, away from the edge -> q=0 immediately, before the next edge.
//   - release rst with s=1 -> q=1 only at the next posedge.
//   - check qb==~q at every sample.

Source files
------------

// File: rtl/sr_pkg.sv
// Shared encodings for the SR flip-flop: forbidden-case modes and the {s,r} function codes.
package sr_pkg;

    localparam int unsigned SR_HOLD    = 0;
    localparam int unsigned SR_RST_DOM = 1;
    localparam int unsigned SR_SET_DOM = 2;
    localparam int unsigned SR_TOGGLE  = 3;

    localparam logic [1:0] SR_FN_HOLD    = 2'b00;
    localparam logic [1:0] SR_FN_SET     = 2'b10;
    localparam logic [1:0] SR_FN_CLR     = 2'b01;
    localparam logic [1:0] SR_FN_INVALID = 2'b11;

    // Next state for s=r=1; any mode outside the defined set behaves as reset-dominant.
    function automatic logic sr_invalid_next(input int unsigned mode, input logic cur);
        logic nxt;
        case (mode)
            SR_HOLD:    nxt = cur;
            SR_SET_DOM: nxt = 1'b1;
            SR_TOGGLE:  nxt = ~cur;
            default:    nxt = 1'b0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sr_ff.sv
// Clocked SR flip-flop with async active-low reset and a parameterised s=r=1 resolution.
module sr_ff
    import sr_pkg::*;
#(
    parameter int unsigned INVALID_MODE = SR_RST_DOM,
    parameter bit          RESET_VAL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic r,
    output logic q,
    output logic qb
);

    logic q_next;

    // Function table on the sampled {s,r}
    always_comb begin
        q_next = q;
        case ({s, r})
            SR_FN_HOLD:    q_next = q;
            SR_FN_SET:     q_next = 1'b1;
            SR_FN_CLR:     q_next = 1'b0;
            SR_FN_INVALID: q_next = sr_invalid_next(INVALID_MODE, q);
            default:       q_next = q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RESET_VAL;
        end else begin
            q <= q_next;
        end
    end

    // Single state bit, so qb can never equal q
    assign qb = ~q;

endmodule

// File: tb/tb_sr_ff.sv
// Randomised self-checking bench: six sr_ff variants against a function-table model.
module tb_sr_ff;

    localparam int unsigned N = 6;

    logic clk;
    logic rst;
    logic s;
    logic r;
    logic [N-1:0] q_vec;
    logic [N-1:0] qb_vec;

    logic [N-1:0] exp_q;
    int unsigned  mode_tab [N] = '{0, 1, 2, 3, 7, 1};
    logic [N-1:0] rst_vals     = 6'b100000;

    int total = 0;
    int bad   = 0;

    sr_ff #(.INVALID_MODE(0), .RESET_VAL(1'b0)) u_hold   (.clk(clk), .rst(rst), .s(s), .r(r), .q(q_vec[0]), .qb(qb_vec[0]));
    sr_ff #(.INVALID_MODE(1), .RESET_VAL(1'b0)) u_rdom   (.clk(clk), .rst(rst), .s(s), .r(r), .q(q_vec[1]), .qb(qb_vec[1]));
    sr_ff #(.INVALID_MODE(2), .RESET_VAL(1'b0)) u_sdom   (.clk(clk), .rst(rst), .s(s), .r(r), .q(q_vec[2]), .qb(qb_vec[2]));
    sr_ff #(.INVALID_MODE(3), .RESET_VAL(1'b0)) u_tog    (.clk(clk), .rst(rst), .s(s), .r(r), .q(q_vec[3]), .qb(qb_vec[3]));
    sr_ff #(.INVALID_MODE(7), .RESET_VAL(1'b0)) u_bad    (.clk(clk), .rst(rst), .s(s), .r(r), .q(q_vec[4]), .qb(qb_vec[4]));
    sr_ff #(.INVALID_MODE(1), .RESET_VAL(1'b1)) u_rv1    (.clk(clk), .rst(rst), .s(s), .r(r), .q(q_vec[5]), .qb(qb_vec[5]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at %0t: got=%b want=%b", tag, $time, got, want);
        end
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".q"},  q_vec,  exp_q);
        check({tag, ".qb"}, qb_vec, ~exp_q);
    endtask

    // Reference behaviour straight from the function table
    function automatic logic ref_next(input int unsigned mode, input logic cur,
                                      input logic si, input logic ri);
        if (si && ri) begin
            if (mode == 0) return cur;
            if (mode == 2) return 1'b1;
            if (mode == 3) return !cur;
            return 1'b0;
        end
        if (si) return 1'b1;
        if (ri) return 1'b0;
        return cur;
    endfunction

    task automatic model_edge(input logic si, input logic ri);
        for (int i = 0; i < N; i++) begin
            exp_q[i] = ref_next(mode_tab[i], exp_q[i], si, ri);
        end
    endtask

    // One clock with values applied at the negedge; junk is driven between edges afterwards
    task automatic cycle(input string tag, input logic si, input logic ri);
        @(negedge clk);
        s = si;
        r = ri;
        @(posedge clk);
        model_edge(si, ri);
        #1;
        check_outs(tag);
        s = 1'($urandom);
        r = 1'($urandom);
        #1;
        check_outs({tag, ".glitch"});
    endtask

    // Assert reset mid-cycle, hold it across an edge, release away from the edge
    task automatic async_reset(input string tag, input logic rel_s, input logic rel_r);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        exp_q = rst_vals;
        check_outs({tag, ".assert"});
        s = 1'($urandom);
        r = 1'($urandom);
        @(posedge clk);
        #1;
        check_outs({tag, ".held"});
        s = rel_s;
        r = rel_r;
        #2;
        rst = 1'b1;
        #1;
        check_outs({tag, ".release"});
        @(posedge clk);
        model_edge(rel_s, rel_r);
        #1;
        check_outs({tag, ".first_edge"});
    endtask

    initial begin
        rst = 1'b1;
        s = 1'b0;
        r = 1'b0;
        exp_q = rst_vals;
        #1;
        rst = 1'b0;
        #1;
        check_outs("reset.t2");
        #4;
        check_outs("reset.edge1");
        #10;
        check_outs("reset.edge2");
        #5;
        rst = 1'b1;
        #1;
        check_outs("reset.release");

        cycle("hold0", 1'b0, 1'b0);
        cycle("set", 1'b1, 1'b0);
        cycle("hold1", 1'b0, 1'b0);
        cycle("clr", 1'b0, 1'b1);
        cycle("inv_from0", 1'b1, 1'b1);
        cycle("set2", 1'b1, 1'b0);
        cycle("inv_from1", 1'b1, 1'b1);
        cycle("inv_again", 1'b1, 1'b1);

        cycle("pre_async", 1'b1, 1'b0);
        async_reset("async_set", 1'b1, 1'b0);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 24) == 0) begin
                async_reset("rnd_async", 1'($urandom), 1'($urandom));
            end else begin
                cycle("rnd", 1'($urandom), 1'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
